note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Stand-alone playback scheduler that sequences the tone datapath: steps through an 8-slot pattern of (note, duration) entries.
- Drives note_index and play toward the wave generator / I2S path.
- Advances on a beat tick from the clock divider and inserts a silent articulation gap between notes.
- Supports one-shot or looping playback, an immediate stop, and live pattern writes from the front-panel state logic.

Parameters:
- STEPS, 8, number of pattern slots; power of two, 2..16.
- NOTE_W, 5, width of the note code.
- MAX_NOTE, 16, highest playable note code; any code above it is treated as a rest.
- REST_CODE, 31, code meaning rest (all ones). Reset fill value.
- GAP_TICKS, 1, silent ticks after every note; 0 disables the gap.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tick  in  1  one-cycle beat pulse, synchronous to clk.
- start  in  1  begin playback from slot 0; ignored while busy.
- stop  in  1  abort playback; has priority over everything.
- loop_en  in  1  1 = wrap from last slot to slot 0; sampled at the end of the last slot.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  log2(STEPS)  slot to write.
- wr_note  in  NOTE_W  note code.
- wr_len  in  2  duration minus one, in ticks (1..4).
- busy  out  1  high in any state other than IDLE.
- play  out  1  audio enable: high only in NOTE with a playable note.
- note_index  out  NOTE_W  current note code; 0 when idle.
- step  out  log2(STEPS)  slot being played.
- done  out  1  one-cycle pulse when a non-looping pass completes.

Behaviour:
- Reset (asynchronous): state=IDLE; step=0; note_index=0; play=0; busy=0; done=0; every slot = note REST_CODE, len 0.
- Pattern storage:
  - Register array, written on the clk edge when wr_en is high; writes are accepted in every state.
  - A LOAD on the same cycle and same slot as a write reads the old contents.
  - A write to the slot currently playing takes effect on its next LOAD.
- States: IDLE, LOAD, NOTE, GAP. All outputs are registered.
- IDLE:
  - start=1 and stop=0 -> LOAD with step=0.
  - done is pulsed only on the exit from GAP/NOTE described below, never while sitting in IDLE.
- LOAD (exactly 1 cycle):
  - Latch note_index = slot note.
  - remaining = wr_len+1 of that slot, minus 1 if tick is high in this cycle.
  - Go to NOTE.
- NOTE:
  - play = (note_index <= MAX_NOTE).
  - On tick, remaining decrements.
  - Exit on the cycle where remaining==0, or where remaining==1 and tick=1.
  - Exit goes to GAP with gap_cnt=GAP_TICKS, or straight to ADVANCE if GAP_TICKS==0.
- GAP:
  - play=0; note_index holds its value.
  - On tick, gap_cnt decrements; at 1 with tick -> ADVANCE.
- ADVANCE (a transition, not a state):
  - If step<STEPS-1: step+1 -> LOAD.
  - Else if loop_en: step=0 -> LOAD.
  - Else: done=1 for one cycle, then IDLE.
- Leaving IDLE for any reason: note_index=0, play=0.
- stop=1 in LOAD/NOTE/GAP:
  - Next cycle: IDLE, play=0, note_index=0, step=0, no done pulse.
  - Simultaneous start+stop in IDLE stays in IDLE.
- start while busy: ignored; it does not restart playback.
- Latency:
  - start -> play high: 2 cycles (IDLE->LOAD->NOTE).
  - Final tick of a note -> play low: 1 cycle.
- Ticks are counted exactly once; none are dropped in LOAD. Minimum tick spacing is 2 clk cycles.
- Widths:
  - remaining counter is 3 bits.
  - gap_cnt is wide enough for GAP_TICKS.
  - step wraps modulo STEPS only via ADVANCE.

Test Plan:
- Reset then start, no writes, loop_en=0:
  - All 8 slots are rests; play stays 0 throughout.
  - With GAP_TICKS=1, busy lasts 16 ticks and done pulses once, then IDLE.
- Write slot0=(note 5, len 2), slot1=(16, 0), start:
  - play high 2 cycles after start with note_index=5 for 3 ticks.
  - 1 gap tick with play=0.
  - Then note_index=16 for 1 tick.
- Write note 20 to slot 2:
  - In slot 2, NOTE has note_index=20 and play=0 (treated as a rest); duration still follows len.
- loop_en=1 through slot 7:
  - step wraps 7->0 with no done pulse; busy stays 1.
- Assert stop in mid-NOTE of slot 3:
  - Next cycle: IDLE, play=0, note_index=0, step=0, done=0.
- Tick coincident with LOAD for len=0:
  - NOTE lasts exactly 1 cycle, then GAP.
- Write slot 1 while slot 1 plays:
  - Current note is unchanged; the new value is heard on the next loop.
- Async rst mid-playback:
  - Outputs clear immediately and the pattern returns to rests.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a small (note, duration) pattern on beat ticks,
// inserting a silent articulation gap after every note. Drives note_index/play
// toward the tone datapath. Supports one-shot or looping playback and live writes.
//
// Handshake: there is no valid/ready pair here. tick is a one-cycle strobe and is
// consumed in the cycle it is high; start is a level sampled only in IDLE; stop
// is sampled every cycle and wins over everything; wr_en commits on the clk edge.
module note_sequencer #(
    parameter int STEPS     = 8,
    parameter int NOTE_W    = 5,
    parameter int MAX_NOTE  = 16,
    parameter int REST_CODE = 31,
    parameter int GAP_TICKS = 1,
    localparam int SW       = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [1:0]        wr_len,
    output logic              busy,
    output logic              play,
    output logic [NOTE_W-1:0] note_index,
    output logic [SW-1:0]     step,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int PW = NOTE_W + 1;
    localparam logic [GW-1:0]     GAP_INIT  = GW'(GAP_TICKS);
    localparam logic [SW-1:0]     LAST_STEP = SW'(STEPS - 1);
    localparam logic [PW-1:0]     MAX_PLAY  = PW'(MAX_NOTE);
    localparam logic [NOTE_W-1:0] REST_FILL = NOTE_W'(REST_CODE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_NOTE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state;
    logic [NOTE_W-1:0] note_mem [STEPS];
    logic [1:0]        len_mem  [STEPS];
    logic [2:0]        remaining;
    logic [GW-1:0]     gap_cnt;

    logic [NOTE_W-1:0] slot_note;
    logic [2:0]        slot_ticks;
    logic              slot_playable;
    logic              note_end;
    logic              gap_end;
    logic              do_adv;
    state_t            adv_state;
    logic [SW-1:0]     adv_step;
    logic              adv_done;

    assign state_dbg     = state;
    assign slot_note     = note_mem[step];
    assign slot_ticks    = {1'b0, len_mem[step]} + 3'd1;
    assign slot_playable = ({1'b0, slot_note} <= MAX_PLAY);
    // remaining==0 only happens when the single tick of a 1-tick note landed in LOAD
    assign note_end      = (remaining == 3'd0) || ((remaining == 3'd1) && tick);
    assign gap_end       = tick && (gap_cnt == GW'(1));
    assign do_adv        = ((state == S_NOTE) && note_end && (GAP_TICKS == 0)) ||
                           ((state == S_GAP) && gap_end);

    // Pattern storage: writes land on the edge, so a same-cycle LOAD sees old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                note_mem[i] <= REST_FILL;
                len_mem[i]  <= 2'd0;
            end
        end else if (wr_en) begin
            note_mem[wr_addr] <= wr_note;
            len_mem[wr_addr]  <= wr_len;
        end
    end

    // Where playback goes after the current slot's note and gap are finished
    always_comb begin
        adv_state = S_LOAD;
        adv_step  = step + SW'(1);
        adv_done  = 1'b0;
        if (step == LAST_STEP) begin
            adv_step = '0;
            if (!loop_en) begin
                adv_state = S_IDLE;
                adv_done  = 1'b1;
            end
        end
    end

    // Playback FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= '0;
            note_index <= '0;
            play       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= 3'd0;
            gap_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (stop && (state != S_IDLE)) begin
                state      <= S_IDLE;
                step       <= '0;
                note_index <= '0;
                play       <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            state      <= S_LOAD;
                            step       <= '0;
                            note_index <= '0;
                            play       <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        note_index <= slot_note;
                        play       <= slot_playable;
                        remaining  <= tick ? (slot_ticks - 3'd1) : slot_ticks;
                        state      <= S_NOTE;
                    end
                    S_NOTE: begin
                        if (tick) remaining <= remaining - 3'd1;
                        if (note_end) begin
                            play <= 1'b0;
                            if (GAP_TICKS > 0) begin
                                state   <= S_GAP;
                                gap_cnt <= GAP_INIT;
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick) gap_cnt <= gap_cnt - GW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
                if (do_adv) begin
                    state <= adv_state;
                    step  <= adv_step;
                    done  <= adv_done;
                    busy  <= (adv_state != S_IDLE);
                    if (adv_done) note_index <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: each scenario builds random tick/write/loop stimulus,
// a timeline model derives the expected per-cycle outputs, and a monitor checks
// every cycle against the queued expectations.
module tb_note_sequencer;

    localparam int N   = 400;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst, tick, start, stop, loop_en, wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_note;
    logic [1:0] wr_len;
    logic       busy, play, done;
    logic [4:0] note_index;
    logic [2:0] step;
    logic [1:0] state_dbg;

    note_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .loop_en(loop_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
        .wr_len(wr_len), .busy(busy), .play(play), .note_index(note_index),
        .step(step), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];
    bit sb_active = 1'b0;
    int scen_done = 0;
    int scen_seen = 0;
    int mon_cycle = 0;

    // scenario stimulus
    bit         tick_v[N];
    bit         loop_v[N];
    bit         wv[N];
    logic [2:0] wa[N];
    logic [4:0] wn[N];
    logic [1:0] wl[N];
    int n_cyc, s_cyc, s2_cyc, p_cyc, r_cyc;

    // reference pattern as the bench believes it is stored
    logic [4:0] pat_note[8];
    logic [1:0] pat_len[8];

    // model results
    bit         m_busy[N], m_play[N], m_done[N], m_innote[N];
    logic [2:0] m_step[N];
    logic [4:0] m_note[N];
    int         m_pass[N];

    task automatic clear_scen(input int n);
        n_cyc = n; s_cyc = -1; s2_cyc = -1; p_cyc = -1; r_cyc = -1;
        for (int c = 0; c < N; c++) begin
            tick_v[c] = 0; loop_v[c] = 0; wv[c] = 0;
            wa[c] = '0; wn[c] = '0; wl[c] = '0;
        end
    endtask

    task automatic gen_ticks();
        int c;
        c = $urandom_range(1, 3);
        while (c < n_cyc) begin
            tick_v[c] = 1;
            c += $urandom_range(2, 4);
        end
    endtask

    task automatic put_w(input int c, input logic [2:0] a, input logic [4:0] nt, input logic [1:0] ln);
        wv[c] = 1; wa[c] = a; wn[c] = nt; wl[c] = ln;
    endtask

    // cycle of the cnt-th tick at or after cycle 'from'
    function automatic int nth_tick(input int from, input int cnt);
        int seen = 0;
        for (int c = from; c < n_cyc; c++) begin
            if (tick_v[c]) begin
                seen++;
                if (seen == cnt) return c;
            end
        end
        return n_cyc + 1000;
    endfunction

    task automatic put(input int c, input bit b, input bit p, input int k, input logic [4:0] nt);
        m_busy[c] = b; m_play[c] = p; m_done[c] = 0; m_step[c] = 3'(k); m_note[c] = nt;
    endtask

    // Timeline model: each slot is one LOAD cycle, a note spanning up to its
    // (len+1)-th tick, then a gap spanning up to the next GAP ticks.
    task automatic model();
        logic [4:0] pn[8];
        logic [1:0] pl[8];
        logic [4:0] nt, prev;
        int L, k, wc, T, E, G, pass, d;
        for (int i = 0; i < 8; i++) begin pn[i] = pat_note[i]; pl[i] = pat_len[i]; end
        for (int c = 0; c < N; c++) begin put(c, 0, 0, 0, 5'd0); m_innote[c] = 0; m_pass[c] = -1; end
        L = s_cyc + 1; k = 0; prev = 5'd0; wc = 0; pass = 0;
        while (s_cyc >= 0 && L < n_cyc) begin
            while (wc < L && wc < n_cyc) begin
                if (wv[wc]) begin pn[wa[wc]] = wn[wc]; pl[wa[wc]] = wl[wc]; end
                wc++;
            end
            nt = pn[k];
            d  = int'(pl[k]) + 1;
            put(L, 1, 0, k, prev);
            T = nth_tick(L, d);
            E = (T > L + 1) ? T : L + 1;
            for (int c = L + 1; c <= E && c < n_cyc; c++) begin
                put(c, 1, (nt <= 5'd16), k, nt);
                m_innote[c] = 1; m_pass[c] = pass;
            end
            G = nth_tick(E + 1, GAP);
            for (int c = E + 1; c <= G && c < n_cyc; c++) put(c, 1, 0, k, nt);
            if (G >= n_cyc) break;
            prev = nt;
            if (k < 7) begin k++; L = G + 1; end
            else if (loop_v[G]) begin k = 0; pass++; L = G + 1; end
            else begin
                if (G + 1 < n_cyc) m_done[G + 1] = 1;
                break;
            end
        end
        if (p_cyc >= 0)
            for (int c = p_cyc + 1; c < n_cyc; c++) begin put(c, 0, 0, 0, 5'd0); m_innote[c] = 0; end
        if (r_cyc >= 0)
            for (int c = r_cyc; c < n_cyc; c++) begin put(c, 0, 0, 0, 5'd0); m_innote[c] = 0; end
    endtask

    task automatic commit_pattern();
        for (int c = 0; c < n_cyc; c++) begin
            if (r_cyc >= 0 && c >= r_cyc) break;
            if (wv[c]) begin pat_note[wa[c]] = wn[c]; pat_len[wa[c]] = wl[c]; end
        end
        if (r_cyc >= 0)
            for (int i = 0; i < 8; i++) begin pat_note[i] = 5'd31; pat_len[i] = 2'd0; end
    endtask

    // driver: queue expectations, then apply the cycle-by-cycle stimulus
    task automatic run_scenario();
        for (int c = 0; c < n_cyc; c++)
            exp_q.push_back({m_busy[c], m_play[c], m_done[c], m_step[c], m_note[c]});
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk); #1;
            rst     = (c == r_cyc);
            tick    = tick_v[c];
            start   = (c == s_cyc) || (c == s2_cyc);
            stop    = (c == p_cyc);
            loop_en = loop_v[c];
            wr_en   = wv[c]; wr_addr = wa[c]; wr_note = wn[c]; wr_len = wl[c];
            if (c == 0) sb_active = 1'b1;
        end
        @(posedge clk); #1;
        rst = 0; tick = 0; start = 0; stop = 0; loop_en = 0; wr_en = 0;
        sb_active = 1'b0;
        scen_done++;
        @(posedge clk);
        commit_pattern();
    endtask

    // scoreboard monitor: one comparison per observed cycle, plus a drain check
    always @(negedge clk) begin
        logic [10:0] act, expv;
        act = {busy, play, done, step, note_index};
        if (sb_active) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL underflow @cycle %0d: got outputs %h, required an expected entry", mon_cycle, act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL outputs @cycle %0d: got busy=%0b play=%0b done=%0b step=%0d note=%0d, required busy=%0b play=%0b done=%0b step=%0d note=%0d",
                             mon_cycle, act[10], act[9], act[8], act[7:5], act[4:0],
                             expv[10], expv[9], expv[8], expv[7:5], expv[4:0]);
                end
            end
            mon_cycle++;
        end else if (scen_seen != scen_done) begin
            scen_seen = scen_done;
            mon_cycle = 0;
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
                exp_q.delete();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic scen_all_rests();
        clear_scen(N); s_cyc = 5; gen_ticks(); model(); run_scenario();
    endtask

    initial begin
        int c1, c3a, c3b, c5, tgt;
        rst = 1; tick = 0; start = 0; stop = 0; loop_en = 0;
        wr_en = 0; wr_addr = '0; wr_note = '0; wr_len = '0;
        for (int i = 0; i < 8; i++) begin pat_note[i] = 5'd31; pat_len[i] = 2'd0; end
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // all rests after reset: silent, 16 ticks busy, one done pulse
        scen_all_rests();

        // directed notes, an over-range note, a spurious start mid-playback
        clear_scen(N);
        put_w(0, 3'd0, 5'd5, 2'd2);
        put_w(1, 3'd1, 5'd16, 2'd0);
        put_w(2, 3'd2, 5'd20, 2'd1);
        for (int i = 3; i < 8; i++) put_w(i, 3'(i), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        s_cyc = 10; gen_ticks(); model();
        for (int c = 0; c < n_cyc; c++) if (m_innote[c] && m_step[c] == 3'd4) begin s2_cyc = c; break; end
        run_scenario();

        // tick coincident with the first LOAD on a 1-tick note
        clear_scen(N);
        put_w(0, 3'd0, 5'd7, 2'd0);
        s_cyc = 10; gen_ticks();
        tick_v[10] = 0; tick_v[11] = 1; tick_v[12] = 0;
        model(); run_scenario();

        // looping: write slot 1 while it plays, write slot 5 in its LOAD cycle,
        // stop in the middle of slot 3 on the second pass
        clear_scen(N);
        for (int i = 0; i < 8; i++) put_w(i, 3'(i), 5'($urandom_range(0, 16)), 2'($urandom_range(0, 1)));
        put_w(1, 3'd1, 5'd9, 2'd1);
        put_w(3, 3'd3, 5'd3, 2'd1);
        s_cyc = 10;
        for (int c = 0; c < N; c++) loop_v[c] = 1;
        gen_ticks(); model();
        c1 = -1; c5 = -1;
        for (int c = 0; c < n_cyc; c++) if (c1 < 0 && m_innote[c] && m_step[c] == 3'd1 && m_pass[c] == 0) c1 = c;
        for (int c = s_cyc + 1; c < n_cyc; c++) if (c5 < 0 && m_busy[c] && m_step[c] == 3'd5) c5 = c;
        if (c1 >= 0) put_w(c1, 3'd1, 5'd12, 2'd2);
        if (c5 >= 0) put_w(c5, 3'd5, 5'd14, 2'd3);
        model();
        c3a = -1; c3b = -1;
        for (int c = 0; c < n_cyc; c++)
            if (m_innote[c] && m_step[c] == 3'd3 && m_pass[c] == 1) begin
                if (c3a < 0) c3a = c;
                c3b = c;
            end
        p_cyc = (c3a >= 0) ? (c3a + c3b) / 2 : n_cyc - 20;
        model(); run_scenario();

        // randomized passes: random pattern, live writes, loop_en and stop
        for (int r = 0; r < 3; r++) begin
            clear_scen(N);
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 3) != 0) put_w(i, 3'(i), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            s_cyc = 10 + $urandom_range(0, 5);
            for (int j = 0; j < 3; j++)
                put_w($urandom_range(s_cyc + 1, 200), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            for (int c = 0; c < N; c++) loop_v[c] = ($urandom_range(0, 1) == 1);
            gen_ticks(); model();
            if (m_busy[n_cyc - 1] || $urandom_range(0, 1) == 1) begin
                tgt = s_cyc + 2 + $urandom_range(0, 150);
                for (int c = tgt; c < n_cyc; c++) if (m_busy[c]) begin p_cyc = c; break; end
            end
            model(); run_scenario();
        end

        // asynchronous reset while a note is sounding
        clear_scen(N);
        put_w(0, 3'd0, 5'd5, 2'd2);
        s_cyc = 5; gen_ticks(); model();
        for (int c = 0; c < n_cyc; c++) if (m_play[c]) begin r_cyc = c + 2; break; end
        if (r_cyc < 0) r_cyc = 20;
        model(); run_scenario();

        // pattern must be back to rests after that reset
        scen_all_rests();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
